id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register and operand-delivery stage directly upstream of the 32-slice ALU array.
//  Latches decoded ID fields and translates opcode/funct into the 3-bit ALU sel plus bin/cin.
//  Resolves EX-operand forwarding from EX/MEM and MEM/WB.
//  Detects load-use hazards and requests a front-end stall while injecting a bubble.
// PARAMETERS
//  DW   32  datapath width (number of ALU slices fed)
//  RW    5  register-index width
// PORTS
//  clk            in   1   rising-edge clock
//  rst_n          in   1   synchronous, active-low reset
//  id_valid       in   1   ID holds a real instruction
//  id_op          in   6   opcode (000000 R-type, 100011 lw, 101011 sw, 000100 beq, 001000 addi)
//  id_funct       in   6   funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt)
//  id_rs,id_rt,id_rd in RW register indices
//  id_rs_data,id_rt_data in DW register-file read data
//  id_imm         in   DW  sign-extended immediate
//  flush          in   1   branch/jump squash of the ID instruction
//  exm_wr,exm_rd,exm_res in 1/RW/DW  EX/MEM write-enable, destination, ALU result
//  mwb_wr,mwb_rd,mwb_res in 1/RW/DW  MEM/WB write-enable, destination, writeback value
//  stall_req      out  1   hold PC and IF/ID (combinational)
//  ex_valid       out  1   EX slot holds a real instruction
//  alu_sel        out  3   000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  alu_bin        out  1   invert B (SUB, SLT, beq)
//  alu_cin        out  1   LSB carry-in (== alu_bin)
//  alu_a,alu_b    out  DW  forwarded operands (alu_b = imm for lw/sw/addi)
//  ex_store_data  out  DW  forwarded rt value for sw
//  ex_rd          out  RW  destination (rd for R-type, rt for lw/addi, 0 otherwise)
//  ex_regwr,ex_memrd,ex_memwr,ex_branch out 1 each  control bits carried to EX/MEM
// BEHAVIOUR
//  - Reset (rst_n=0 at an edge): every registered field cleared.
//    ex_valid=0, alu_sel=010, all control bits 0, ex_rd=0, operands 0.
//  - Latency: one cycle ID->EX. Forwarding muxes are combinational off the EX-stage registers.
//  - Load-use: stall_req=1 when ex_valid & ex_memrd & ex_rd!=0 & id_valid & (ex_rd==id_rs | ex_rd==id_rt).
//    The register then loads a bubble; IF/ID holds externally.
//  - Bubble = valid=0, all control bits 0, ex_rd=0; data fields don't-care, zeroed.
//  - flush has priority over stall_req: loads a bubble; stall_req still reports.
//  - Otherwise the register loads the ID fields with ex_valid=id_valid.
//  - Decode: R-type by funct. Unknown funct or opcode yields ADD with regwr=0 (treated as a nop).
//    lw/sw/addi use ADD; beq uses SUB.
//  - Forward A (and identically B/store):
//    EX/MEM when exm_wr & exm_rd!=0 & exm_rd==rs;
//    else MEM/WB when mwb_wr & mwb_rd!=0 & mwb_rd==rs;
//    else latched data. EX/MEM wins when both match; register 0 is never forwarded.
//  - Immediate select happens after forwarding; the forwarded rt still drives ex_store_data.
//  - rst_n low mid-stall: reset wins; the next cycle shows a bubble and stall_req depends only on inputs.
// STRUCTURE
//  - Shared package/header alu_defs.vh: ALU sel localparams (AND/OR/ADD/SUB/SLT), opcode/funct codes, DW/RW defaults.
//    The ALU slice array uses the same header.
//  - One sub-module, fwd_mux (DW-wide 3:1 priority mux with match logic), instantiated three times (A, B, store).
//  - Decode and hazard logic stay inline.
// TESTING
//  1. Reset: rst_n=0 for 2 clks with random inputs -> ex_valid=0, alu_sel=010, regwr=0, ex_rd=0.
//  2. sub $3,$1,$2 (rs=1 data 9, rt=2 data 4), no hazards -> next cycle alu_sel=110, bin=cin=1, a=9, b=4, ex_rd=3, regwr=1.
//  3. EX/MEM writes $1=0x55 and MEM/WB writes $1=0x66 while EX rs=1 -> alu_a=0x55.
//     Then drop exm_wr -> alu_a=0x66. Any rd=0 match -> latched data.
//  4. lw $5 in EX, ID add $6,$5,$7 -> stall_req=1 for exactly 1 cycle, bubble in EX (valid=0).
//     Following cycle the add issues with alu_a from the MEM/WB forward.
//  5. flush=1 together with a load-use stall -> bubble loaded, no control bit asserted.
//  6. addi $4,$2,-3 with rt_data=0x10 -> alu_b=0xFFFFFFFD, sel=010, ex_rd=4, store data = forwarded $4 path unused.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: shared ALU select, opcode and funct encodings plus the ID-stage decoder
package id_ex_stage_pkg;
  localparam int DW_DEF = 32;
  localparam int RW_DEF = 5;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  typedef struct packed {
    logic [2:0] sel;
    logic       regwr;
    logic       memrd;
    logic       memwr;
    logic       branch;
    logic       use_imm;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{ALU_ADD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_R: begin
        c.sel = funct == FN_SUB ? ALU_SUB : funct == FN_AND ? ALU_AND : funct == FN_OR ? ALU_OR :
                funct == FN_SLT ? ALU_SLT : ALU_ADD;
        c.regwr = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
      end
      OP_LW: begin
        c.regwr = 1'b1;
        c.memrd = 1'b1;
        c.use_imm = 1'b1;
      end
      OP_SW: begin
        c.memwr = 1'b1;
        c.use_imm = 1'b1;
      end
      OP_BEQ: begin
        c.sel = ALU_SUB;
        c.branch = 1'b1;
      end
      OP_ADDI: begin
        c.regwr = 1'b1;
        c.use_imm = 1'b1;
      end
      default: c = CTRL_NOP;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// fwd_mux: EX/MEM-over-MEM/WB-over-latched operand forwarding, register 0 never forwarded
module fwd_mux
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] latched,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mwb_wr,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_res,
  output logic [DW-1:0] y
);
  always_comb
    y = (exm_wr && |exm_rd && exm_rd == idx) ? exm_res :
        (mwb_wr && |mwb_rd && mwb_rd == idx) ? mwb_res : latched;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with ALU decode, operand forwarding and load-use stall
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int RW = RW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          id_valid,
  input  logic [5:0]    id_op,
  input  logic [5:0]    id_funct,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          flush,
  input  logic          exm_wr,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_res,
  input  logic          mwb_wr,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_res,
  output logic          stall_req,
  output logic          ex_valid,
  output logic [2:0]    alu_sel,
  output logic          alu_bin,
  output logic          alu_cin,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_regwr,
  output logic          ex_memrd,
  output logic          ex_memwr,
  output logic          ex_branch
);
  logic          valid_q, valid_d, bubble;
  ctrl_t         ctrl_q, ctrl_d, dec;
  logic [RW-1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d, dst;
  logic [DW-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d, imm_q, imm_d, fwd_b;
  always_comb begin
    dec = id_valid ? decode(id_op, id_funct) : CTRL_NOP;
    dst = dec.regwr ? (id_op == OP_R ? id_rd : id_rt) : '0;
    stall_req = valid_q & ctrl_q.memrd & (|rd_q) & id_valid & (rd_q == id_rs | rd_q == id_rt);
    bubble = flush | stall_req;
    valid_d = id_valid & ~bubble;
    ctrl_d = bubble ? CTRL_NOP : dec;
    rd_d = bubble ? '0 : dst;
    rs_d = bubble ? '0 : id_rs;
    rt_d = bubble ? '0 : id_rt;
    rs_data_d = bubble ? '0 : id_rs_data;
    rt_data_d = bubble ? '0 : id_rt_data;
    imm_d = bubble ? '0 : id_imm;
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q <= CTRL_NOP;
      rd_q <= '0;
      rs_q <= '0;
      rt_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q <= ctrl_d;
      rd_q <= rd_d;
      rs_q <= rs_d;
      rt_q <= rt_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q <= imm_d;
    end
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_a (
    .idx(rs_q), .latched(rs_data_q), .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res), .y(alu_a)
  );
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_b (
    .idx(rt_q), .latched(rt_data_q), .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res), .y(fwd_b)
  );
  fwd_mux #(.DW(DW), .RW(RW)) u_fwd_st (
    .idx(rt_q), .latched(rt_data_q), .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res), .y(ex_store_data)
  );
  assign ex_valid = valid_q;
  assign alu_sel = ctrl_q.sel;
  assign alu_bin = ctrl_q.sel == ALU_SUB || ctrl_q.sel == ALU_SLT;
  assign alu_cin = alu_bin;
  assign alu_b = ctrl_q.use_imm ? imm_q : fwd_b;
  assign ex_rd = rd_q;
  assign ex_regwr = ctrl_q.regwr;
  assign ex_memrd = ctrl_q.memrd;
  assign ex_memwr = ctrl_q.memwr;
  assign ex_branch = ctrl_q.branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against a mnemonic-level model
module tb_id_ex_stage;
  logic        clk = 1'b0, rst_n = 1'b0, id_valid = 1'b0, flush = 1'b0;
  logic [5:0]  id_op = '0, id_funct = '0;
  logic [4:0]  id_rs = '0, id_rt = '0, id_rd = '0, exm_rd = '0, mwb_rd = '0;
  logic [31:0] id_rs_data = '0, id_rt_data = '0, id_imm = '0, exm_res = '0, mwb_res = '0;
  logic        exm_wr = 1'b0, mwb_wr = 1'b0;
  logic        stall_req, ex_valid, alu_bin, alu_cin, ex_regwr, ex_memrd, ex_memwr, ex_branch;
  logic [2:0]  alu_sel;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0]  ex_rd;
  int checks = 0, errors = 0;
  logic        m_valid;
  string       m_mn;
  logic [4:0]  m_rs, m_rt, m_rdf;
  logic [31:0] m_rsd, m_rtd, m_imm;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .flush(flush), .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_res(exm_res),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_res(mwb_res), .stall_req(stall_req), .ex_valid(ex_valid),
    .alu_sel(alu_sel), .alu_bin(alu_bin), .alu_cin(alu_cin), .alu_a(alu_a), .alu_b(alu_b),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .ex_memwr(ex_memwr), .ex_branch(ex_branch)
  );

  always #5 clk = ~clk;

  function automatic string mn_of(logic v, logic [5:0] op, logic [5:0] fn);
    if (!v) return "nop";
    if (op == 6'h00)
      return fn == 6'h20 ? "add" : fn == 6'h22 ? "sub" : fn == 6'h24 ? "and" : fn == 6'h25 ? "or" :
             fn == 6'h2a ? "slt" : "nop";
    return op == 6'h23 ? "lw" : op == 6'h2b ? "sw" : op == 6'h04 ? "beq" : op == 6'h08 ? "addi" : "nop";
  endfunction

  function automatic logic [2:0] sel_of(string m);
    return m == "and" ? 3'b000 : m == "or" ? 3'b001 : (m == "sub" || m == "beq") ? 3'b110 :
           m == "slt" ? 3'b111 : 3'b010;
  endfunction

  function automatic logic is_rtype(string m);
    return m == "add" || m == "sub" || m == "and" || m == "or" || m == "slt";
  endfunction

  function automatic logic [31:0] fwd(logic [4:0] idx, logic [31:0] lat);
    if (exm_wr && exm_rd != 0 && exm_rd == idx) return exm_res;
    if (mwb_wr && mwb_rd != 0 && mwb_rd == idx) return mwb_res;
    return lat;
  endfunction

  task automatic idle();
    id_valid = 0; flush = 0; exm_wr = 0; mwb_wr = 0; exm_rd = 0; mwb_rd = 0;
  endtask

  task automatic drive(logic v, logic [5:0] op, logic [5:0] fn, logic [4:0] rs, logic [4:0] rt,
                       logic [4:0] rd, logic [31:0] rsd, logic [31:0] rtd, logic [31:0] imm);
    id_valid = v; id_op = op; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    drive(1, 6'h23, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), $urandom, $urandom, $urandom);
    exm_wr = 1; exm_rd = 5'($urandom); exm_res = $urandom; mwb_wr = 1; mwb_rd = 5'($urandom); mwb_res = $urandom;
    tick();
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", ex_valid); end
    checks++; if (alu_sel !== 3'b010) begin errors++; $display("FAIL reset_sel got %0h exp 2", alu_sel); end
    checks++; if (ex_regwr !== 1'b0) begin errors++; $display("FAIL reset_regwr got %0h exp 0", ex_regwr); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got %0h exp 0", ex_rd); end
    checks++; if ({ex_memrd, ex_memwr, ex_branch} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %0h exp 0", {ex_memrd, ex_memwr, ex_branch}); end
    checks++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin errors++; $display("FAIL reset_ops got %h/%h exp 0/0", alu_a, alu_b); end
    rst_n = 1;
    idle();
  endtask

  task automatic test_sub();
    idle();
    drive(1, 6'h00, 6'h22, 1, 2, 3, 9, 4, 0);
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %0h exp 1", ex_valid); end
    checks++; if (alu_sel !== 3'b110) begin errors++; $display("FAIL sub_sel got %0h exp 6", alu_sel); end
    checks++; if ({alu_bin, alu_cin} !== 2'b11) begin errors++; $display("FAIL sub_bincin got %0h exp 3", {alu_bin, alu_cin}); end
    checks++; if (alu_a !== 32'd9) begin errors++; $display("FAIL sub_a got %h exp 9", alu_a); end
    checks++; if (alu_b !== 32'd4) begin errors++; $display("FAIL sub_b got %h exp 4", alu_b); end
    checks++; if (ex_rd !== 5'd3 || ex_regwr !== 1'b1) begin errors++; $display("FAIL sub_dst got rd=%0d wr=%0h exp rd=3 wr=1", ex_rd, ex_regwr); end
  endtask

  task automatic test_forward();
    id_valid = 0;
    exm_wr = 1; exm_rd = 1; exm_res = 32'h55; mwb_wr = 1; mwb_rd = 1; mwb_res = 32'h66;
    #1;
    checks++; if (alu_a !== 32'h55) begin errors++; $display("FAIL fwd_exm_wins got %h exp 55", alu_a); end
    exm_wr = 0;
    #1;
    checks++; if (alu_a !== 32'h66) begin errors++; $display("FAIL fwd_mwb got %h exp 66", alu_a); end
    exm_wr = 1; exm_rd = 2; exm_res = 32'h77;
    #1;
    checks++; if (alu_b !== 32'h77 || ex_store_data !== 32'h77) begin errors++; $display("FAIL fwd_b got %h/%h exp 77/77", alu_b, ex_store_data); end
    idle();
    drive(1, 6'h00, 6'h20, 0, 0, 7, 32'h99, 32'h88, 0);
    tick();
    exm_wr = 1; exm_rd = 0; exm_res = 32'h11; mwb_wr = 1; mwb_rd = 0; mwb_res = 32'h22;
    #1;
    checks++; if (alu_a !== 32'h99 || alu_b !== 32'h88) begin errors++; $display("FAIL fwd_r0 got %h/%h exp 99/88", alu_a, alu_b); end
    idle();
  endtask

  task automatic test_load_use();
    idle();
    drive(1, 6'h23, 0, 1, 5, 0, 32'h100, 0, 4);
    tick();
    checks++; if (ex_memrd !== 1'b1 || ex_rd !== 5'd5) begin errors++; $display("FAIL lu_lw got memrd=%0h rd=%0d exp 1/5", ex_memrd, ex_rd); end
    drive(1, 6'h00, 6'h20, 5, 7, 6, 32'hdead, 32'h7, 0);
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL lu_stall got %0h exp 1", stall_req); end
    tick();
    checks++; if (ex_valid !== 1'b0 || ex_regwr !== 1'b0) begin errors++; $display("FAIL lu_bubble got v=%0h wr=%0h exp 0/0", ex_valid, ex_regwr); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL lu_stall_once got %0h exp 0", stall_req); end
    mwb_wr = 1; mwb_rd = 5; mwb_res = 32'h1234;
    tick();
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'h1234) begin errors++; $display("FAIL lu_issue got v=%0h a=%h exp 1/1234", ex_valid, alu_a); end
    checks++; if (ex_rd !== 5'd6 || alu_b !== 32'h7 || alu_sel !== 3'b010) begin errors++; $display("FAIL lu_add got rd=%0d b=%h sel=%0h exp 6/7/2", ex_rd, alu_b, alu_sel); end
    idle();
  endtask

  task automatic test_flush();
    idle();
    drive(1, 6'h23, 0, 1, 5, 0, 32'h100, 0, 4);
    tick();
    drive(1, 6'h00, 6'h20, 5, 7, 6, 1, 2, 0);
    flush = 1;
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL flush_stall got %0h exp 1", stall_req); end
    tick();
    checks++; if ({ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_branch} !== 5'b0) begin errors++; $display("FAIL flush_bubble got %b exp 00000", {ex_valid, ex_regwr, ex_memrd, ex_memwr, ex_branch}); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL flush_rd got %0d exp 0", ex_rd); end
    idle();
  endtask

  task automatic test_addi();
    idle();
    drive(1, 6'h08, 0, 2, 4, 0, 32'h20, 32'h10, 32'hFFFFFFFD);
    tick();
    checks++; if (alu_b !== 32'hFFFFFFFD) begin errors++; $display("FAIL addi_b got %h exp fffffffd", alu_b); end
    checks++; if (alu_sel !== 3'b010 || alu_bin !== 1'b0) begin errors++; $display("FAIL addi_sel got %0h/%0h exp 2/0", alu_sel, alu_bin); end
    checks++; if (ex_rd !== 5'd4 || ex_regwr !== 1'b1) begin errors++; $display("FAIL addi_dst got rd=%0d wr=%0h exp 4/1", ex_rd, ex_regwr); end
    checks++; if (alu_a !== 32'h20 || ex_store_data !== 32'h10) begin errors++; $display("FAIL addi_a_st got %h/%h exp 20/10", alu_a, ex_store_data); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    idle();
    drive(1, 6'h23, 0, 1, 5, 0, 0, 0, 0);
    tick();
    drive(1, 6'h00, 6'h20, 3, 5, 6, 0, 0, 0);
    #1;
    checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL rst_stall_pre got %0h exp 1", stall_req); end
    rst_n = 0;
    tick();
    checks++; if (ex_valid !== 1'b0 || stall_req !== 1'b0) begin errors++; $display("FAIL rst_stall_post got v=%0h s=%0h exp 0/0", ex_valid, stall_req); end
    rst_n = 1;
    idle();
  endtask

  task automatic test_random();
    logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h3f};
    logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    logic exp_stall;
    logic [4:0] e_rd;
    logic e_imm;
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    m_valid = 0; m_mn = "nop"; m_rs = 0; m_rt = 0; m_rdf = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 7) != 0, ops[$urandom_range(0, 9)], fns[$urandom_range(0, 5)],
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom);
      flush = $urandom_range(0, 7) == 0;
      exp_stall = m_valid && m_mn == "lw" && m_rt != 0 && id_valid && (m_rt == id_rs || m_rt == id_rt);
      #1;
      checks++; if (stall_req !== exp_stall) begin errors++; $display("FAIL rnd_stall[%0d] got %0h exp %0h", i, stall_req, exp_stall); end
      @(posedge clk);
      if (flush || exp_stall) begin
        m_valid = 0; m_mn = "nop"; m_rs = 0; m_rt = 0; m_rdf = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
      end else begin
        m_valid = id_valid; m_mn = mn_of(id_valid, id_op, id_funct); m_rs = id_rs; m_rt = id_rt;
        m_rdf = id_rd; m_rsd = id_rs_data; m_rtd = id_rt_data; m_imm = id_imm;
      end
      #1;
      exm_wr = 1'($urandom); exm_rd = 5'($urandom_range(0, 3)); exm_res = $urandom;
      mwb_wr = 1'($urandom); mwb_rd = 5'($urandom_range(0, 3)); mwb_res = $urandom;
      #1;
      e_rd = is_rtype(m_mn) ? m_rdf : (m_mn == "lw" || m_mn == "addi") ? m_rt : 5'd0;
      e_imm = m_mn == "lw" || m_mn == "sw" || m_mn == "addi";
      checks++; if (ex_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %0h exp %0h", i, ex_valid, m_valid); end
      checks++; if (alu_sel !== sel_of(m_mn)) begin errors++; $display("FAIL rnd_sel[%0d] %s got %0h exp %0h", i, m_mn, alu_sel, sel_of(m_mn)); end
      checks++; if ({alu_bin, alu_cin} !== {2{sel_of(m_mn) inside {3'b110, 3'b111}}}) begin errors++; $display("FAIL rnd_bin[%0d] %s got %b", i, m_mn, {alu_bin, alu_cin}); end
      checks++; if (ex_rd !== e_rd) begin errors++; $display("FAIL rnd_rd[%0d] %s got %0d exp %0d", i, m_mn, ex_rd, e_rd); end
      checks++; if ({ex_regwr, ex_memrd, ex_memwr, ex_branch} !== {is_rtype(m_mn) || m_mn == "lw" || m_mn == "addi", m_mn == "lw", m_mn == "sw", m_mn == "beq"}) begin errors++; $display("FAIL rnd_ctrl[%0d] %s got %b", i, m_mn, {ex_regwr, ex_memrd, ex_memwr, ex_branch}); end
      checks++; if (alu_a !== fwd(m_rs, m_rsd)) begin errors++; $display("FAIL rnd_a[%0d] got %h exp %h", i, alu_a, fwd(m_rs, m_rsd)); end
      checks++; if (alu_b !== (e_imm ? m_imm : fwd(m_rt, m_rtd))) begin errors++; $display("FAIL rnd_b[%0d] got %h exp %h", i, alu_b, e_imm ? m_imm : fwd(m_rt, m_rtd)); end
      checks++; if (ex_store_data !== fwd(m_rt, m_rtd)) begin errors++; $display("FAIL rnd_st[%0d] got %h exp %h", i, ex_store_data, fwd(m_rt, m_rtd)); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_sub();
    test_forward();
    test_load_use();
    test_flush();
    test_addi();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
